// File: rtl/universal_shift_register.sv
`default_nettype none
// ============================================================================
//  Module      : universal_shift_register
//  Description : Parallel-load register with a WIDTH-bit serial transfer,
//                left/right shift and rotate modes, busy/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module universal_shift_register #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] p_in,
    input  logic             start,
    input  logic             dir,
    input  logic             rotate,
    input  logic             sin,
    output logic             sout,
    output logic [WIDTH-1:0] status,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    count
);

    localparam logic [1:0]    c_st_idle  = 2'd0;
    localparam logic [1:0]    c_st_shift = 2'd1;
    localparam logic [1:0]    c_st_done  = 2'd2;
    localparam logic [CW-1:0] c_last     = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_status;
    logic [CW-1:0]    r_count;
    logic             r_dir;
    logic             r_rot;

    logic             w_dir_eff;
    logic             w_exit_bit;
    logic             w_entry_bit;
    logic [WIDTH-1:0] w_shifted;

    // Outside a transfer, sout previews the bit the dir port would select.
    assign w_dir_eff   = (r_state == c_st_shift) ? r_dir : dir;
    assign w_exit_bit  = w_dir_eff ? r_status[WIDTH-1] : r_status[0];
    assign w_entry_bit = r_rot ? w_exit_bit : sin;

    always_comb begin
        w_shifted = r_status;
        if (r_dir) begin
            w_shifted = {r_status[WIDTH-2:0], w_entry_bit};
        end else begin
            w_shifted = {w_entry_bit, r_status[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_st_idle;
            r_status <= '0;
            r_count  <= '0;
            r_dir    <= 1'b0;
            r_rot    <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (load) begin
                        r_status <= p_in;
                    end else if (start) begin
                        r_state <= c_st_shift;
                        r_count <= '0;
                        r_dir   <= dir;
                        r_rot   <= rotate;
                    end
                end
                c_st_shift: begin
                    r_status <= w_shifted;
                    r_count  <= r_count + CW'(1);
                    if (r_count == c_last) begin
                        r_state <= c_st_done;
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign sout   = w_exit_bit;
    assign status = r_status;
    assign count  = r_count;
    assign busy   = (r_state == c_st_shift);
    assign done   = (r_state == c_st_done);

endmodule
`default_nettype wire

// File: tb/tb_universal_shift_register.sv
`default_nettype none
// ============================================================================
//  Module      : tb_universal_shift_register
//  Description : Randomized and directed scoreboard bench for the shift register.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_universal_shift_register;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset, load, start, dir, rotate, sin;
    logic [W-1:0]  p_in;
    logic          sout, busy, done;
    logic [W-1:0]  status;
    logic [CW-1:0] count;

    universal_shift_register #(.WIDTH(W), .CW(CW)) dut (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .p_in   (p_in),
        .start  (start),
        .dir    (dir),
        .rotate (rotate),
        .sin    (sin),
        .sout   (sout),
        .status (status),
        .busy   (busy),
        .done   (done),
        .count  (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         sout;
        logic [W-1:0] status;
        logic         busy;
        logic         done;
        int           count;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_bad   = 0;

    // Behavioural model: mode 0 = idle, 1 = transferring, 2 = finished.
    int           m_mode;
    int           m_val;
    int           m_cnt;
    int           m_ldir;
    int           m_lrot;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Applies one cycle of inputs, predicts the outputs after the next edge.
    task automatic step(input logic r, input logic ld, input logic [W-1:0] pi,
                        input logic st, input logic d, input logic ro, input logic si);
        exp_t e;
        int   out_bit;
        int   in_bit;
        int   full;
        reset = r; load = ld; p_in = pi; start = st; dir = d; rotate = ro; sin = si;
        full = 1 << W;
        if (r) begin
            m_mode = 0; m_val = 0; m_cnt = 0; m_ldir = 0; m_lrot = 0;
        end else if (m_mode == 0) begin
            if (ld) begin
                m_val = int'(pi);
            end else if (st) begin
                m_mode = 1; m_cnt = 0; m_ldir = int'(d); m_lrot = int'(ro);
            end
        end else if (m_mode == 1) begin
            out_bit = m_ldir ? (m_val / (full / 2)) % 2 : m_val % 2;
            in_bit  = m_lrot ? out_bit : int'(si);
            if (m_ldir != 0) m_val = (m_val * 2) % full + in_bit;
            else             m_val = m_val / 2 + in_bit * (full / 2);
            m_cnt++;
            if (m_cnt == W) m_mode = 2;
        end else begin
            m_mode = 0;
        end
        e.status = m_val[W-1:0];
        e.busy   = (m_mode == 1);
        e.done   = (m_mode == 2);
        e.count  = m_cnt;
        e.sout   = ((m_mode == 1) ? (m_ldir != 0) : d) ? ((m_val / (full / 2)) % 2 == 1)
                                                      : (m_val % 2 == 1);
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Monitor: every cycle the DUT presents a new state; compare it to the queue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sout",   32'(sout),   32'(e.sout));
                chk("status", 32'(status), 32'(e.status));
                chk("busy",   32'(busy),   32'(e.busy));
                chk("done",   32'(done),   32'(e.done));
                chk("count",  32'(count),  32'(e.count));
            end
        end
    end

    // Load 8'b10010010, run one transfer with fixed sin, checking sout order.
    task automatic xfer(input logic d, input logic ro, input logic si, input logic [W-1:0] fin);
        logic [W-1:0] pat;
        pat = 8'b10010010;
        step(0, 1, pat, 0, 0, 0, 0);
        step(0, 0, 0, 1, d, ro, si);
        for (int i = 0; i < W; i++) begin
            chk("sout_seq", 32'(sout), 32'(d ? pat[W-1-i] : pat[i]));
            step(0, 0, 0, 0, 1'($urandom), 1'($urandom), si);
        end
        chk("xfer_final_status", 32'(status), 32'(fin));
        chk("xfer_final_count", 32'(count), 32'(W));
        chk("xfer_done_pulse", 32'(done), 32'd1);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("xfer_done_cleared", 32'(done), 32'd0);
        chk("xfer_count_held", 32'(count), 32'(W));
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; start = 1'b0; dir = 1'b0; rotate = 1'b0;
        sin = 1'b0; p_in = '0;
        m_mode = 0; m_val = 0; m_cnt = 0; m_ldir = 0; m_lrot = 0;
        @(posedge clk);
        #2;

        step(1, 1, 8'hFF, 1, 1, 1, 1);
        step(1, 0, 8'h00, 0, 1, 0, 0);
        chk("reset_status", 32'(status), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_sout_dir1", 32'(sout), 32'd0);

        xfer(0, 0, 0, 8'h00);
        xfer(0, 1, 0, 8'b10010010);
        xfer(1, 0, 1, 8'hFF);

        // Load request mid-transfer must be ignored.
        step(0, 1, 8'h5C, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0, 1'($urandom));
        repeat (5) step(0, 1, 8'hAA, 1, 0, 1, 1'($urandom));
        chk("midload_count", 32'(count), 32'(W));
        chk("midload_done", 32'(done), 32'd1);
        step(0, 0, 0, 0, 0, 0, 0);

        // Reset aborting a transfer after four shifts.
        step(0, 0, 0, 1, 0, 1, 0);
        repeat (4) step(0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("abort_status", 32'(status), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_count", 32'(count), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            chk("abort_no_done", 32'(done), 32'd0);
        end

        // Simultaneous load and start: load wins, start next cycle begins.
        step(0, 1, 8'h3C, 1, 0, 0, 0);
        chk("ldst_status", 32'(status), 32'h3C);
        chk("ldst_busy", 32'(busy), 32'd0);
        step(0, 0, 0, 1, 1, 0, 0);
        chk("ldst_start_busy", 32'(busy), 32'd1);
        repeat (W + 1) step(0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) == 0), W'($urandom),
                 ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        @(posedge clk);
        #3;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/universal_shift_register.md
UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; legal range 2..32.
REQ-002 Parameter CW, default $clog2(WIDTH+1), width of the shift counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 load  input  1  parallel-load request; sampled on the rising edge.
REQ-006 p_in  input  WIDTH  parallel load data.
REQ-007 start  input  1  request a serial transfer of WIDTH bits.
REQ-008 dir  input  1  shift direction: 0 = right (LSB out first), 1 = left (MSB out first).
REQ-009 rotate  input  1  1 = the exiting bit re-enters at the opposite end and sin is ignored; 0 = sin enters.
REQ-010 sin  input  1  serial input bit.
REQ-011 sout  output  1  serial output: the bit that leaves on the next shift edge.
REQ-012 status  output  WIDTH  current register contents.
REQ-013 busy  output  1  high while in SHIFT.
REQ-014 done  output  1  one-cycle pulse after a transfer completes.
REQ-015 count  output  CW  number of shifts completed in the current transfer.

Function
REQ-016 FSM states: IDLE, SHIFT, DONE; state is held in a registered encoding.
REQ-017 IDLE with load=1: status <= p_in; start is ignored in the same cycle (load has priority); the FSM stays in IDLE.
REQ-018 IDLE with load=0 and start=1: the FSM moves to SHIFT.
- count <= 0.
- dir and rotate are latched into internal registers.
- status is not shifted on this edge.
REQ-019 IDLE with neither load nor start: status and count hold.
REQ-020 SHIFT state: one shift occurs on every edge, and count increments on each shift.
REQ-021 Each shift uses the latched dir/rotate values; changes on the dir and rotate ports during SHIFT have no effect.
REQ-022 Right shift: status <= {rotate ? status[0] : sin, status[WIDTH-1:1]}.
REQ-023 Left shift: status <= {status[WIDTH-2:0], rotate ? status[WIDTH-1] : sin}.
REQ-024 sin is sampled on each shift edge.
REQ-025 On the shift edge where count reaches WIDTH, the FSM moves to DONE.
- Exactly WIDTH shifts occur per transfer.
- busy is high for exactly WIDTH cycles.
REQ-026 DONE state: done=1 for exactly one cycle; status and count hold; the next state is IDLE unconditionally.
REQ-027 load and start are ignored in SHIFT and DONE; no queuing of requests.
REQ-028 sout is combinational: dir_eff ? status[WIDTH-1] : status[0].
- dir_eff = latched dir in SHIFT.
- dir_eff = the dir port otherwise.
REQ-029 busy = (state==SHIFT) and done = (state==DONE), both decoded combinationally from registered state.
REQ-030 count holds its final value (WIDTH) through DONE and IDLE until the next accepted start.

Reset
REQ-031 reset=1 on a rising edge forces:
- state = IDLE
- status = 0
- count = 0
- latched dir = 0, latched rotate = 0
REQ-032 Reset has priority over load and start and aborts any transfer in progress; done is not pulsed for an aborted transfer.
REQ-033 While reset is held, outputs are: sout=0 (for dir=0 or 1), busy=0, done=0, status=0, count=0.

Verification (WIDTH=8)
REQ-034 Load 8'b10010010; start with dir=0, rotate=0, sin=0 -> sout over 8 shift cycles = 0,1,0,0,1,0,0,1; final status=8'h00; count=8; done high one cycle after the 8th shift.
REQ-035 Load 8'b10010010; start with dir=0, rotate=1 -> after 8 shifts status=8'b10010010; the sout sequence matches REQ-034.
REQ-036 Load 8'b10010010; start with dir=1, rotate=0, sin=1 -> sout = 1,0,0,1,0,0,1,0; final status=8'hFF.
REQ-037 Start a transfer, then assert load=1 with p_in=8'hAA after 3 shifts -> load is ignored; the transfer finishes normally with count=8.
REQ-038 Assert reset after 4 shifts -> next cycle status=0, busy=0, count=0; no done pulse follows.
REQ-039 load=1 and start=1 in the same IDLE cycle -> status=p_in; busy stays 0; a start on the next cycle begins the transfer.
